// File: rtl/latch_bank_write_arbiter.sv
// Round-robin write arbiter for a bank of gated D latches.
// Grants one requester, captures its address/data, then sequences a
// glitch-free latch write: data setup, enable pulse, data hold, ack.
// Every output comes straight from a flop, so latch_en cannot glitch.
module latch_bank_write_arbiter #(
  parameter int unsigned N_REQ     = 4,
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned ADDR_W    = 2,
  parameter int unsigned SETUP_CYC = 1,
  parameter int unsigned EN_CYC    = 1,
  parameter int unsigned HOLD_CYC  = 1
) (
  input  logic                      Clk,
  input  logic                      Resetn,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ*ADDR_W-1:0]   wr_addr,
  input  logic [N_REQ*WIDTH-1:0]    wr_data,
  output logic [N_REQ-1:0]          gnt,
  output logic [N_REQ-1:0]          ack,
  output logic [WIDTH-1:0]          latch_d,
  output logic [(1<<ADDR_W)-1:0]    latch_en,
  output logic                      busy
);

  localparam int unsigned NWORDS  = 1 << ADDR_W;
  localparam int unsigned PTR_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned MAX_SE  = (SETUP_CYC > EN_CYC) ? SETUP_CYC : EN_CYC;
  localparam int unsigned MAX_CYC = (MAX_SE > HOLD_CYC) ? MAX_SE : HOLD_CYC;
  localparam int unsigned CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] EN_LAST    = CNT_W'(EN_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYC - 1);
  localparam logic [PTR_W-1:0] PTR_LAST   = PTR_W'(N_REQ - 1);

  typedef enum logic [2:0] {StIdle, StSetup, StEnable, StHold, StAck} state_e;

  state_e              state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [PTR_W-1:0]    ptr_q;
  logic [PTR_W-1:0]    win_q;
  logic [ADDR_W-1:0]   addr_q;

  logic                win_valid;
  logic [PTR_W-1:0]    win_idx;
  int unsigned         win_int;
  int unsigned         idx;

  // Round-robin search: first set request bit starting at ptr_q, wrapping.
  always_comb begin
    win_valid = 1'b0;
    win_idx   = '0;
    win_int   = 0;
    idx       = 0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      idx = (32'(ptr_q) + k) % N_REQ;
      if (!win_valid && req[idx]) begin
        win_valid = 1'b1;
        win_int   = idx;
        win_idx   = PTR_W'(idx);
      end
    end
  end

  // Write sequencer: grant capture, phase timing and all registered outputs.
  always_ff @(posedge Clk or negedge Resetn) begin
    if (!Resetn) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      ptr_q    <= '0;
      win_q    <= '0;
      addr_q   <= '0;
      gnt      <= '0;
      ack      <= '0;
      latch_d  <= '0;
      latch_en <= '0;
      busy     <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (win_valid) begin
            gnt     <= N_REQ'(1) << win_idx;
            latch_d <= wr_data[win_int*WIDTH +: WIDTH];
            addr_q  <= wr_addr[win_int*ADDR_W +: ADDR_W];
            win_q   <= win_idx;
            busy    <= 1'b1;
            cnt_q   <= '0;
            state_q <= StSetup;
          end
        end
        StSetup: begin
          if (cnt_q == SETUP_LAST) begin
            cnt_q    <= '0;
            latch_en <= NWORDS'(1) << addr_q;
            state_q  <= StEnable;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StEnable: begin
          if (cnt_q == EN_LAST) begin
            cnt_q    <= '0;
            latch_en <= '0;
            state_q  <= StHold;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StHold: begin
          if (cnt_q == HOLD_LAST) begin
            cnt_q   <= '0;
            ack     <= gnt;
            // Winner drops to lowest priority for the next round.
            ptr_q   <= (win_q == PTR_LAST) ? '0 : win_q + 1'b1;
            state_q <= StAck;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StAck: begin
          gnt     <= '0;
          ack     <= '0;
          busy    <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          state_q  <= StIdle;
          latch_en <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_latch_bank_write_arbiter.sv
// Self-checking bench for latch_bank_write_arbiter: directed vector table,
// hand-written corner sequences and a randomized run against a timeline model.
module tb_latch_bank_write_arbiter;

  localparam int N  = 4;
  localparam int S  = 1;
  localparam int E  = 1;
  localparam int H  = 1;
  localparam int S2 = 2;
  localparam int E2 = 3;
  localparam int H2 = 2;

  logic        Clk = 1'b0;
  logic        Resetn = 1'b0;
  logic [3:0]  req = '0;
  logic [7:0]  wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic [3:0]  gnt, ack, latch_en;
  logic [7:0]  latch_d;
  logic        busy;

  logic [3:0]  req2 = '0;
  logic [7:0]  wr_addr2 = 8'h03;
  logic [31:0] wr_data2 = 32'h0000_00B7;
  logic [3:0]  gnt2, ack2, latch_en2;
  logic [7:0]  latch_d2;
  logic        busy2;

  latch_bank_write_arbiter #(
    .N_REQ(4), .WIDTH(8), .ADDR_W(2), .SETUP_CYC(S), .EN_CYC(E), .HOLD_CYC(H)
  ) dut (
    .Clk(Clk), .Resetn(Resetn), .req(req), .wr_addr(wr_addr), .wr_data(wr_data),
    .gnt(gnt), .ack(ack), .latch_d(latch_d), .latch_en(latch_en), .busy(busy)
  );

  latch_bank_write_arbiter #(
    .N_REQ(4), .WIDTH(8), .ADDR_W(2), .SETUP_CYC(S2), .EN_CYC(E2), .HOLD_CYC(H2)
  ) dut2 (
    .Clk(Clk), .Resetn(Resetn), .req(req2), .wr_addr(wr_addr2), .wr_data(wr_data2),
    .gnt(gnt2), .ack(ack2), .latch_d(latch_d2), .latch_en(latch_en2), .busy(busy2)
  );

  always #5 Clk = ~Clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    @(negedge Clk);
  endtask

  task automatic do_reset();
    Resetn = 1'b0;
    repeat (2) @(negedge Clk);
    Resetn = 1'b1;
  endtask

  // Timeline model: a transaction is a fixed sequence of cycles after the grant.
  int          m_active, m_t, m_w, m_addr, m_ptr;
  logic [7:0]  m_d;

  task automatic model_reset();
    m_active = 0; m_t = 0; m_w = 0; m_addr = 0; m_ptr = 0; m_d = '0;
  endtask

  task automatic model_edge();
    int found;
    found = 0;
    if (m_active != 0) begin
      m_t++;
      if (m_t == S + E + H + 1) m_active = 0;
    end else if (req != 0) begin
      for (int k = 0; k < N; k++) begin
        int i;
        i = (m_ptr + k) % N;
        if (found == 0 && req[i]) begin
          found = 1;
          m_w = i;
        end
      end
      m_addr   = int'(wr_addr[m_w*2 +: 2]);
      m_d      = wr_data[m_w*8 +: 8];
      m_ptr    = (m_w + 1) % N;
      m_active = 1;
      m_t      = 0;
    end
  endtask

  typedef struct {
    logic [3:0]  req;
    logic [7:0]  addr;
    logic [31:0] data;
    logic [3:0]  gnt;
    logic [3:0]  en;
    logic [7:0]  d;
  } vec_t;

  vec_t tbl[6];

  initial begin
    logic [31:0] e_gnt, e_en, e_ack;
    int t;

    tbl[0] = '{4'b0010, 8'h08, 32'h0000_A500, 4'b0010, 4'b0100, 8'hA5};
    tbl[1] = '{4'b1001, 8'h43, 32'h5A00_00C3, 4'b1000, 4'b0010, 8'h5A};
    tbl[2] = '{4'b1001, 8'h43, 32'h5A00_00C3, 4'b0001, 4'b1000, 8'hC3};
    tbl[3] = '{4'b0101, 8'h00, 32'h007E_0011, 4'b0100, 4'b0001, 8'h7E};
    tbl[4] = '{4'b0111, 8'h01, 32'h0000_00FF, 4'b0001, 4'b0010, 8'hFF};
    tbl[5] = '{4'b1111, 8'h0C, 32'h0000_3C00, 4'b0010, 4'b1000, 8'h3C};

    // Reset state
    @(negedge Clk);
    check("rst_gnt", gnt, 0);
    check("rst_ack", ack, 0);
    check("rst_en", latch_en, 0);
    check("rst_d", latch_d, 0);
    check("rst_busy", busy, 0);
    do_reset();

    // Directed vectors; winner drops req and scrambles data right after grant
    for (int v = 0; v < 6; v++) begin
      req = tbl[v].req; wr_addr = tbl[v].addr; wr_data = tbl[v].data;
      step();
      check($sformatf("v%0d_gnt", v), gnt, tbl[v].gnt);
      check($sformatf("v%0d_d", v), latch_d, tbl[v].d);
      check($sformatf("v%0d_busy", v), busy, 1);
      check($sformatf("v%0d_en_setup", v), latch_en, 0);
      req = '0; wr_data = ~tbl[v].data; wr_addr = ~tbl[v].addr;
      step();
      check($sformatf("v%0d_en", v), latch_en, tbl[v].en);
      check($sformatf("v%0d_d_en", v), latch_d, tbl[v].d);
      step();
      check($sformatf("v%0d_en_hold", v), latch_en, 0);
      check($sformatf("v%0d_ack_early", v), ack, 0);
      step();
      check($sformatf("v%0d_ack", v), ack, tbl[v].gnt);
      check($sformatf("v%0d_gnt_ack", v), gnt, tbl[v].gnt);
      step();
      check($sformatf("v%0d_idle_busy", v), busy, 0);
      check($sformatf("v%0d_idle_gnt", v), gnt, 0);
      check($sformatf("v%0d_idle_ack", v), ack, 0);
      check($sformatf("v%0d_idle_d", v), latch_d, tbl[v].d);
    end

    // All requesting from reset: grants 0,1,2,3,0 five cycles apart
    req = 4'b1111; wr_addr = 8'hE4; wr_data = 32'h4433_2211;
    do_reset();
    for (int k = 0; k < 5; k++) begin
      step();
      check($sformatf("rr%0d_gnt", k), gnt, 32'(1) << (k % 4));
      check($sformatf("rr%0d_d", k), latch_d, 32'h11 * ((k % 4) + 1));
      step();
      check($sformatf("rr%0d_en", k), latch_en, 32'(1) << (k % 4));
      check($sformatf("rr%0d_d_en", k), latch_d, 32'h11 * ((k % 4) + 1));
      repeat (3) step();
    end

    // Async reset mid-ENABLE with ptr previously moved to 3
    req = '0;
    do_reset();
    req = 4'b0100; wr_addr = 8'h20; wr_data = 32'h0099_0000;
    step();
    req = '0;
    repeat (4) step();
    req = 4'b0100;
    step();
    check("ar_gnt", gnt, 4'b0100);
    req = '0;
    step();
    check("ar_en", latch_en, 4'b0100);
    #2 Resetn = 1'b0;
    #1;
    check("ar_en_drop", latch_en, 0);
    check("ar_gnt_drop", gnt, 0);
    check("ar_busy_drop", busy, 0);
    check("ar_d_drop", latch_d, 0);
    @(negedge Clk);
    Resetn = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      check($sformatf("ar_noack%0d", k), ack, 0);
      check($sformatf("ar_idle%0d", k), busy, 0);
    end
    req = 4'b1010; wr_addr = 8'h00; wr_data = 32'h0000_0000;
    step();
    check("ar_ptr0", gnt, 4'b0010);
    req = '0;
    repeat (5) step();

    // Stretched timing instance: en for 3 cycles from t=2, ack at t=7, period 9
    do_reset();
    req2 = 4'b0001;
    for (int c = 0; c < 18; c++) begin
      step();
      t = c % 9;
      check($sformatf("p2_gnt_c%0d", c), gnt2, (t <= S2 + E2 + H2) ? 1 : 0);
      check($sformatf("p2_en_c%0d", c), latch_en2, (t >= S2 && t < S2 + E2) ? 4'b1000 : 0);
      check($sformatf("p2_ack_c%0d", c), ack2, (t == S2 + E2 + H2) ? 1 : 0);
      check($sformatf("p2_d_c%0d", c), latch_d2, 8'hB7);
    end
    req2 = '0;

    // Randomized traffic against the timeline model
    do_reset();
    model_reset();
    for (int c = 0; c < 600; c++) begin
      req     = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) req = '0;
      wr_addr = 8'($urandom);
      wr_data = $urandom;
      @(posedge Clk);
      model_edge();
      @(negedge Clk);
      e_gnt = (m_active != 0) ? (32'(1) << m_w) : 0;
      e_en  = (m_active != 0 && m_t >= S && m_t < S + E) ? (32'(1) << m_addr) : 0;
      e_ack = (m_active != 0 && m_t == S + E + H) ? (32'(1) << m_w) : 0;
      check("rnd_gnt", gnt, e_gnt);
      check("rnd_en", latch_en, e_en);
      check("rnd_ack", ack, e_ack);
      check("rnd_d", latch_d, m_d);
      check("rnd_busy", busy, m_active != 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
